// File: rtl/memory_bus_controller.sv
// memory_bus_controller
//   CPU-to-memory interconnect. The top SEL_BITS address bits split the
//   address space into NUM_SLAVES equal regions. Each region has its own
//   wait-state count and read-only flag. Every bus-side output is
//   registered. The CPU sees a one-cycle cpuReady pulse when an access
//   completes, and busError pulses in that same cycle when the access
//   failed.
//
// Ports
//   clk, reset         clock; asynchronous active-low reset
//   cpuAddress         access address (region select in the top SEL_BITS bits)
//   cpuDataOut         write data from the CPU
//   cpuRead/cpuWrite   request strobes, held until cpuReady
//   cpuDataIn          registered read data (last read result)
//   cpuReady           one-cycle completion pulse
//   busError           one-cycle error pulse, coincident with cpuReady
//   slvChipSelect      one-hot registered chip selects
//   slvAddress         registered offset within the selected region
//   slvWriteEnable     registered write strobe
//   slvDataOut         registered write data
//   slvDataIn          packed slave read data, slave i at [DATA_WIDTH*i +: DATA_WIDTH]
module memory_bus_controller #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 8,
    parameter int SEL_BITS   = 2,
    parameter logic [4*(2**SEL_BITS)-1:0] WAIT_STATES    = 16'h0210,
    parameter logic [(2**SEL_BITS)-1:0]   READ_ONLY_MASK = 4'b0001
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic [ADDR_WIDTH-1:0]                cpuAddress,
    input  logic [DATA_WIDTH-1:0]                cpuDataOut,
    input  logic                                 cpuRead,
    input  logic                                 cpuWrite,
    output logic [DATA_WIDTH-1:0]                cpuDataIn,
    output logic                                 cpuReady,
    output logic                                 busError,
    output logic [(2**SEL_BITS)-1:0]             slvChipSelect,
    output logic [ADDR_WIDTH-SEL_BITS-1:0]       slvAddress,
    output logic                                 slvWriteEnable,
    output logic [DATA_WIDTH-1:0]                slvDataOut,
    input  logic [(2**SEL_BITS)*DATA_WIDTH-1:0]  slvDataIn
);

    localparam int NUM_SLAVES = 2**SEL_BITS;
    localparam int OFF_W      = ADDR_WIDTH - SEL_BITS;

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    state_t                  state_q, state_d;
    logic [SEL_BITS-1:0]     sel_q,   sel_d;
    logic [OFF_W-1:0]        addr_q,  addr_d;
    logic                    wr_q,    wr_d;
    logic                    err_q,   err_d;
    logic [3:0]              cnt_q,   cnt_d;
    logic [NUM_SLAVES-1:0]   cs_q,    cs_d;
    logic                    we_q,    we_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
    logic                    ready_q, ready_d;
    logic                    berr_q,  berr_d;

    logic [SEL_BITS-1:0]     req_sel;
    logic                    req_conflict;
    logic                    req_valid;

    assign req_sel      = cpuAddress[ADDR_WIDTH-1 -: SEL_BITS];
    assign req_conflict = cpuRead & cpuWrite;
    assign req_valid    = cpuRead ^ cpuWrite;

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        addr_d  = addr_q;
        wr_d    = wr_q;
        err_d   = err_q;
        cnt_d   = cnt_q;
        cs_d    = cs_q;
        we_d    = we_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        ready_d = 1'b0;
        berr_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (req_conflict) begin
                    // A conflict never reaches a slave. It completes
                    // through DONE with an error and all-ones read data.
                    rdata_d = '1;
                    err_d   = 1'b1;
                    wr_d    = 1'b0;
                    state_d = DONE;
                end else if (req_valid) begin
                    sel_d   = req_sel;
                    addr_d  = cpuAddress[OFF_W-1:0];
                    wr_d    = cpuWrite;
                    wdata_d = cpuDataOut;
                    cnt_d   = WAIT_STATES[4*req_sel +: 4];
                    cs_d    = NUM_SLAVES'(1) << req_sel;
                    // A write to a protected region still selects the slave
                    // for the full access time. The strobe stays low and the
                    // access is flagged as an error.
                    we_d    = cpuWrite & ~READ_ONLY_MASK[req_sel];
                    err_d   = cpuWrite &  READ_ONLY_MASK[req_sel];
                    state_d = ACCESS;
                end
            end

            ACCESS: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    if (!wr_q) begin
                        rdata_d = slvDataIn[DATA_WIDTH*sel_q +: DATA_WIDTH];
                    end
                    cs_d    = '0;
                    we_d    = 1'b0;
                    state_d = DONE;
                end
            end

            DONE: begin
                // cpuReady is a registered output, so the pulse appears in
                // the cycle after DONE. That cycle is spent in IDLE, and a
                // request still held during it is sampled as a new access.
                ready_d = 1'b1;
                berr_d  = err_q;
                err_d   = 1'b0;
                state_d = IDLE;
            end

            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            sel_q   <= '0;
            addr_q  <= '0;
            wr_q    <= 1'b0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
            cs_q    <= '0;
            we_q    <= 1'b0;
            wdata_q <= '0;
            rdata_q <= '0;
            ready_q <= 1'b0;
            berr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            addr_q  <= addr_d;
            wr_q    <= wr_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
            cs_q    <= cs_d;
            we_q    <= we_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            ready_q <= ready_d;
            berr_q  <= berr_d;
        end
    end

    assign cpuDataIn      = rdata_q;
    assign cpuReady       = ready_q;
    assign busError       = berr_q;
    assign slvChipSelect  = cs_q;
    assign slvAddress     = addr_q;
    assign slvWriteEnable = we_q;
    assign slvDataOut     = wdata_q;

endmodule

// File: tb/tb_memory_bus_controller.sv
module tb_memory_bus_controller;

    localparam logic [15:0] WAIT = 16'h0210;
    localparam logic [3:0]  RO   = 4'b0001;

    logic        clk;
    logic        reset;
    logic [15:0] cpuAddress;
    logic [7:0]  cpuDataOut;
    logic        cpuRead;
    logic        cpuWrite;
    logic [7:0]  cpuDataIn;
    logic        cpuReady;
    logic        busError;
    logic [3:0]  slvChipSelect;
    logic [13:0] slvAddress;
    logic        slvWriteEnable;
    logic [7:0]  slvDataOut;
    logic [31:0] slvDataIn;
    logic [7:0]  slv_val [4];

    assign slvDataIn = {slv_val[3], slv_val[2], slv_val[1], slv_val[0]};

    memory_bus_controller dut (
        .clk(clk), .reset(reset), .cpuAddress(cpuAddress), .cpuDataOut(cpuDataOut),
        .cpuRead(cpuRead), .cpuWrite(cpuWrite), .cpuDataIn(cpuDataIn),
        .cpuReady(cpuReady), .busError(busError), .slvChipSelect(slvChipSelect),
        .slvAddress(slvAddress), .slvWriteEnable(slvWriteEnable),
        .slvDataOut(slvDataOut), .slvDataIn(slvDataIn)
    );

    typedef struct {
        logic [7:0]  data;
        bit          err;
        int          cyc;
        int          cs_cyc;
        int          we_cyc;
        logic [3:0]  cs;
        logic [13:0] addr;
        logic [7:0]  wd;
        bit          wr;
    } exp_t;

    exp_t       q[$];
    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    logic [7:0] last_rd = 8'h00;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Monitor: accumulate what the slave side saw during an access and
    // score it against the oldest expectation when cpuReady appears.
    initial begin
        int         cs_n;
        int         we_n;
        logic [3:0] cs_seen;
        logic [13:0] addr_seen;
        logic [7:0] wd_seen;
        exp_t       e;
        cs_n = 0; we_n = 0; cs_seen = '0; addr_seen = '0; wd_seen = '0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                cs_n = 0; we_n = 0; cs_seen = '0;
            end else begin
                if (slvChipSelect != 4'b0) begin
                    cs_n++;
                    cs_seen   = slvChipSelect;
                    addr_seen = slvAddress;
                    wd_seen   = slvDataOut;
                end
                if (slvWriteEnable) we_n++;
                if (cpuReady) begin
                    if (q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_ready: got cpuReady=1 expected no completion (cycle %0d)", cyc);
                    end else begin
                        e = q.pop_front();
                        chk("ready_cycle", cyc, e.cyc);
                        chk("cpuDataIn", {24'h0, cpuDataIn}, {24'h0, e.data});
                        chk("busError", {31'h0, busError}, {31'h0, e.err});
                        chk("cs_cycles", cs_n, e.cs_cyc);
                        chk("we_cycles", we_n, e.we_cyc);
                        if (e.cs_cyc > 0) begin
                            chk("chip_select", {28'h0, cs_seen}, {28'h0, e.cs});
                            chk("slvAddress", {18'h0, addr_seen}, {18'h0, e.addr});
                            if (e.wr) chk("slvDataOut", {24'h0, wd_seen}, {24'h0, e.wd});
                        end
                    end
                    cs_n = 0; we_n = 0; cs_seen = '0;
                end
            end
        end
    end

    // Issue one request and hold it until `reps` completions have been seen.
    // The expected responses come from the region rules: wait count from the
    // slave's nibble, completion 3+W cycles after the sample edge (2 for a
    // conflict), and a held request repeats every 3+W cycles.
    task automatic issue(input bit rd, input bit wr, input logic [15:0] addr,
                         input logic [7:0] wd, input int reps);
        int   s;
        int   w;
        int   got;
        bit   conflict;
        bit   prot;
        exp_t e;
        @(posedge clk); #1;
        s        = int'(addr[15:14]);
        w        = int'((WAIT >> (4 * s)) & 16'hF);
        conflict = rd && wr;
        prot     = wr && !rd && RO[s];
        cpuAddress = addr; cpuDataOut = wd; cpuRead = rd; cpuWrite = wr;
        for (int r = 0; r < reps; r++) begin
            if (conflict)  last_rd = 8'hFF;
            else if (rd)   last_rd = slv_val[s];
            e.data   = last_rd;
            e.err    = conflict || prot;
            e.cyc    = conflict ? cyc + 2 : cyc + 3 + w + r * (3 + w);
            e.cs_cyc = conflict ? 0 : w + 1;
            e.we_cyc = (wr && !rd && !prot) ? w + 1 : 0;
            e.cs     = 4'(1 << s);
            e.addr   = addr[13:0];
            e.wd     = wd;
            e.wr     = wr && !rd;
            q.push_back(e);
        end
        got = 0;
        for (int t = 0; t < 40 * reps && got < reps; t++) begin
            @(negedge clk);
            if (cpuReady) got++;
        end
        cpuRead = 1'b0; cpuWrite = 1'b0;
        if (got < reps) begin
            checks++;
            errors++;
            $display("FAIL ready_timeout: got %0d completions expected %0d", got, reps);
            q.delete();
        end
    endtask

    initial begin
        int pick;
        reset = 1'b0; cpuAddress = '0; cpuDataOut = '0; cpuRead = 1'b0; cpuWrite = 1'b0;
        for (int i = 0; i < 4; i++) slv_val[i] = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_cs", {28'h0, slvChipSelect}, 32'h0);
        chk("rst_ready", {31'h0, cpuReady}, 32'h0);
        chk("rst_berr", {31'h0, busError}, 32'h0);
        chk("rst_data", {24'h0, cpuDataIn}, 32'h0);
        chk("rst_we", {31'h0, slvWriteEnable}, 32'h0);
        chk("rst_addr", {18'h0, slvAddress}, 32'h0);
        chk("rst_wdata", {24'h0, slvDataOut}, 32'h0);
        reset = 1'b1;

        slv_val[0] = 8'hA5; slv_val[1] = 8'h11; slv_val[2] = 8'h22; slv_val[3] = 8'h33;
        issue(1, 0, 16'h0005, 8'h00, 1);
        issue(0, 1, 16'h4010, 8'h3C, 1);
        issue(0, 1, 16'h0100, 8'h77, 1);
        issue(1, 1, 16'h8000, 8'h00, 1);
        issue(1, 0, 16'hFFFF, 8'h00, 1);
        issue(1, 0, 16'h7FFF, 8'h00, 1);
        issue(1, 0, 16'h4002, 8'h00, 3);
        issue(1, 0, 16'h0003, 8'h00, 2);

        // Reset during the second ACCESS cycle of a slave-2 read.
        @(posedge clk); #1;
        cpuAddress = 16'h8001; cpuRead = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #2;
        chk("abort_cs_before", {28'h0, slvChipSelect}, 32'h4);
        reset = 1'b0;
        #1;
        chk("abort_cs_async", {28'h0, slvChipSelect}, 32'h0);
        chk("abort_ready", {31'h0, cpuReady}, 32'h0);
        chk("abort_data", {24'h0, cpuDataIn}, 32'h0);
        cpuRead = 1'b0;
        last_rd = 8'h00;
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        issue(1, 0, 16'h8001, 8'h00, 1);

        for (int n = 0; n < 60; n++) begin
            for (int i = 0; i < 4; i++) slv_val[i] = 8'($urandom);
            pick = int'($urandom_range(0, 9));
            if (pick < 5)      issue(1, 0, 16'($urandom), 8'($urandom), 1);
            else if (pick < 9) issue(0, 1, 16'($urandom), 8'($urandom), 1);
            else               issue(1, 1, 16'($urandom), 8'($urandom), 1);
            repeat ($urandom_range(0, 2)) @(posedge clk);
        end

        repeat (5) @(posedge clk);
        chk("queue_empty", q.size(), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
